// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: receive-side byte buffer behind a UART receiver.
// Captures each byte the receiver flags ready, acknowledges it through the
// clear-ready handshake and queues it in a circular FIFO of 2^DEPTH_LOG2 bytes.
// Provides empty/full/count status and a sticky overflow flag for dropped bytes.
//
// Optional feature macro: UART_RX_FIFO_FWFT_EN
//   defined   -> first-word fall-through read port (head byte always visible,
//                valid_o = !empty_o, zero read latency)
//   undefined -> registered read port (data_o/valid_o one cycle after read_i)
//
// Handshake: the receiver raises rx_ready_i and keeps it high until it sees
// rx_clear_ready_o; the capture FSM takes exactly one byte per ready assertion
// and holds rx_clear_ready_o high until rx_ready_i falls, so the clear pulse is
// always low again before the receiver can present the next byte. On the
// consumer side, read_i is a pop request that is accepted only when the FIFO
// is not empty; requests while empty are silently ignored.
module uart_rx_fifo #(
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                  reset_i,
    input  logic                  clock_i,
    input  logic [7:0]            rx_data_i,
    input  logic                  rx_ready_i,
    output logic                  rx_clear_ready_o,
    input  logic                  read_i,
    output logic [7:0]            data_o,
    output logic                  valid_o,
    output logic                  empty_o,
    output logic                  full_o,
    output logic [DEPTH_LOG2:0]   count_o,
    output logic                  overflow_o,
    input  logic                  clear_overflow_i
);

    localparam int DEPTH = 1 << DEPTH_LOG2;

    typedef enum logic {
        IDLE = 1'b0,
        ACK  = 1'b1
    } state_t;

    state_t                  state_q;
    logic                    clear_q;
    logic [7:0]              mem_q [DEPTH];
    logic [DEPTH_LOG2-1:0]   wr_ptr_q;
    logic [DEPTH_LOG2-1:0]   rd_ptr_q;
    logic [DEPTH_LOG2:0]     count_q;
    logic [DEPTH_LOG2:0]     count_d;
    logic                    overflow_q;

    logic empty;
    logic full;
    logic capture;
    logic pop;
    logic wr_en;
    logic drop;

    // Count never exceeds DEPTH, so its MSB alone marks the full condition.
    assign empty   = (count_q == '0);
    assign full    = count_q[DEPTH_LOG2];
    assign capture = (state_q == IDLE) && rx_ready_i;
    assign pop     = read_i && !empty;
    // A full FIFO still accepts the byte when the head leaves in the same cycle.
    assign wr_en   = capture && (!full || pop);
    assign drop    = capture && full && !pop;

    // Occupancy next-state: simultaneous write and pop leaves it unchanged.
    always_comb begin
        count_d = count_q;
        case ({wr_en, pop})
            2'b10:   count_d = count_q + (DEPTH_LOG2 + 1)'(1);
            2'b01:   count_d = count_q - (DEPTH_LOG2 + 1)'(1);
            default: count_d = count_q;
        endcase
    end

    // Capture FSM: one capture per ready assertion, registered clear-ready.
    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= IDLE;
            clear_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (rx_ready_i) begin
                        clear_q <= 1'b1;
                        state_q <= ACK;
                    end
                end
                ACK: begin
                    if (!rx_ready_i) begin
                        clear_q <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                default: begin
                    clear_q <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // Byte storage; contents are meaningless until written, so no reset.
    always_ff @(posedge clock_i) begin
        if (wr_en) begin
            mem_q[wr_ptr_q] <= rx_data_i;
        end
    end

    // Pointers wrap naturally modulo depth; count tracks occupancy.
    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr_q <= wr_ptr_q + DEPTH_LOG2'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + DEPTH_LOG2'(1);
            end
            count_q <= count_d;
        end
    end

    // Sticky overflow: a drop in the same cycle as a clear keeps it set.
    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            overflow_q <= 1'b0;
        end else if (drop) begin
            overflow_q <= 1'b1;
        end else if (clear_overflow_i) begin
            overflow_q <= 1'b0;
        end
    end

`ifdef UART_RX_FIFO_FWFT_EN
    // Fall-through read port: head byte is presented combinationally.
    assign data_o  = mem_q[rd_ptr_q];
    assign valid_o = !empty;
`else
    logic [7:0] data_q;
    logic       valid_q;

    // Registered read port: popped byte appears for one cycle, then holds.
    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            data_q  <= 8'h00;
            valid_q <= 1'b0;
        end else begin
            valid_q <= pop;
            if (pop) begin
                data_q <= mem_q[rd_ptr_q];
            end
        end
    end

    assign data_o  = data_q;
    assign valid_o = valid_q;
`endif

    assign rx_clear_ready_o = clear_q;
    assign empty_o          = empty;
    assign full_o           = full;
    assign count_o          = count_q;
    assign overflow_o       = overflow_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo: self-checking bench for uart_rx_fifo.
// A queue-based reference model of the FIFO is updated once per clock from
// the stimulus; outputs are sampled 1 ns after each rising edge.
module tb_uart_rx_fifo;

    localparam int DEPTH_LOG2 = 4;
    localparam int DEPTH      = 1 << DEPTH_LOG2;

    logic                clk;
    logic                rst;
    logic [7:0]          rx_data;
    logic                rx_ready;
    logic                rx_clear_ready;
    logic                rd;
    logic [7:0]          data;
    logic                valid;
    logic                empty;
    logic                full;
    logic [DEPTH_LOG2:0] count;
    logic                overflow;
    logic                clr_ovf;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [7:0] mdl_q[$];
    logic       mdl_ovf;
    logic       mdl_valid;
    logic [7:0] mdl_data;

    uart_rx_fifo #(.DEPTH_LOG2(DEPTH_LOG2)) dut (
        .reset_i          (rst),
        .clock_i          (clk),
        .rx_data_i        (rx_data),
        .rx_ready_i       (rx_ready),
        .rx_clear_ready_o (rx_clear_ready),
        .read_i           (rd),
        .data_o           (data),
        .valid_o          (valid),
        .empty_o          (empty),
        .full_o           (full),
        .count_o          (count),
        .overflow_o       (overflow),
        .clear_overflow_i (clr_ovf)
    );

    // Clock generation
    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [DEPTH_LOG2:0] exp_count();
        return (DEPTH_LOG2 + 1)'(mdl_q.size());
    endfunction

    function automatic logic exp_valid();
`ifdef UART_RX_FIFO_FWFT_EN
        return mdl_q.size() > 0;
`else
        return mdl_valid;
`endif
    endfunction

    function automatic logic [7:0] exp_data();
`ifdef UART_RX_FIFO_FWFT_EN
        return (mdl_q.size() > 0) ? mdl_q[0] : 8'h00;
`else
        return mdl_data;
`endif
    endfunction

    function automatic logic data_checked();
`ifdef UART_RX_FIFO_FWFT_EN
        return mdl_q.size() > 0;
`else
        return 1'b1;
`endif
    endfunction

    // One clock: apply inputs, advance model, step past the edge.
    // cap marks the first cycle of a ready assertion (the capture cycle).
    task automatic cyc(input logic rdy, input logic cap, input logic [7:0] b,
                       input logic rd_in, input logic clr);
        int  sz;
        logic popped;
        rx_ready = rdy;
        rx_data  = b;
        rd       = rd_in;
        clr_ovf  = clr;
        sz       = mdl_q.size();
        popped   = rd_in && (sz > 0);
        mdl_valid = popped;
        if (popped) mdl_data = mdl_q.pop_front();
        if (clr) mdl_ovf = 1'b0;
        if (cap) begin
            if (sz < DEPTH || popped) mdl_q.push_back(b);
            else mdl_ovf = 1'b1;
        end
        @(posedge clk);
        #1;
    endtask

    // Receiver driver: ready for two cycles, dropped in the third.
    task automatic send_byte(input logic [7:0] b);
        cyc(1'b1, 1'b1, b, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, b, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, b, 1'b0, 1'b0);
    endtask

    task automatic apply_reset();
        rst      = 1'b1;
        rx_ready = 1'b0;
        rx_data  = 8'h00;
        rd       = 1'b0;
        clr_ovf  = 1'b0;
        mdl_q.delete();
        mdl_ovf   = 1'b0;
        mdl_valid = 1'b0;
        mdl_data  = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        apply_reset();
        checks += 7;
        if (rx_clear_ready !== 1'b0) begin errors++; $display("FAIL reset_clear got %b want 0", rx_clear_ready); end
        if (data !== 8'h00 && data_checked()) begin errors++; $display("FAIL reset_data got %h want 00", data); end
        if (valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", valid); end
        if (empty !== 1'b1) begin errors++; $display("FAIL reset_empty got %b want 1", empty); end
        if (full !== 1'b0) begin errors++; $display("FAIL reset_full got %b want 0", full); end
        if (count !== '0) begin errors++; $display("FAIL reset_count got %0d want 0", count); end
        if (overflow !== 1'b0) begin errors++; $display("FAIL reset_ovf got %b want 0", overflow); end
    endtask

    task automatic test_single_byte();
        cyc(1'b1, 1'b1, 8'hA5, 1'b0, 1'b0);
        checks += 3;
        if (count !== 5'd1) begin errors++; $display("FAIL a5_count got %0d want 1", count); end
        if (rx_clear_ready !== 1'b1) begin errors++; $display("FAIL a5_clear_n1 got %b want 1", rx_clear_ready); end
        if (valid !== exp_valid()) begin errors++; $display("FAIL a5_valid_pre got %b want %b", valid, exp_valid()); end
        cyc(1'b1, 1'b0, 8'hA5, 1'b0, 1'b0);
        checks += 2;
        if (rx_clear_ready !== 1'b1) begin errors++; $display("FAIL a5_clear_n2 got %b want 1", rx_clear_ready); end
        if (count !== 5'd1) begin errors++; $display("FAIL a5_one_write got %0d want 1", count); end
        cyc(1'b0, 1'b0, 8'hA5, 1'b0, 1'b0);
        checks += 1;
        if (rx_clear_ready !== 1'b0) begin errors++; $display("FAIL a5_clear_n3 got %b want 0", rx_clear_ready); end
`ifdef UART_RX_FIFO_FWFT_EN
        checks += 2;
        if (valid !== 1'b1) begin errors++; $display("FAIL fwft_valid got %b want 1", valid); end
        if (data !== 8'hA5) begin errors++; $display("FAIL fwft_data got %h want a5", data); end
`endif
        cyc(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        checks += 2;
        if (empty !== 1'b1) begin errors++; $display("FAIL a5_empty got %b want 1", empty); end
        if (valid !== exp_valid()) begin errors++; $display("FAIL a5_valid got %b want %b", valid, exp_valid()); end
`ifndef UART_RX_FIFO_FWFT_EN
        checks += 1;
        if (data !== 8'hA5) begin errors++; $display("FAIL a5_data got %h want a5", data); end
`endif
        cyc(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        checks += 1;
        if (valid !== 1'b0) begin errors++; $display("FAIL a5_valid_pulse got %b want 0", valid); end
    endtask

    // Pops every stored byte, checking order against the model.
    task automatic drain_and_check(input string tag);
        logic [7:0] head;
        while (mdl_q.size() > 0) begin
            head = mdl_q[0];
`ifdef UART_RX_FIFO_FWFT_EN
            checks += 2;
            if (valid !== 1'b1) begin errors++; $display("FAIL %s_valid got %b want 1", tag, valid); end
            if (data !== head) begin errors++; $display("FAIL %s_data got %h want %h", tag, data, head); end
            cyc(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
`else
            cyc(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
            checks += 2;
            if (valid !== 1'b1) begin errors++; $display("FAIL %s_valid got %b want 1", tag, valid); end
            if (data !== head) begin errors++; $display("FAIL %s_data got %h want %h", tag, data, head); end
`endif
        end
        checks += 1;
        if (empty !== 1'b1) begin errors++; $display("FAIL %s_empty got %b want 1", tag, empty); end
    endtask

    task automatic test_fill_wrap();
        for (int i = 0; i < DEPTH; i++) send_byte(8'(i));
        checks += 2;
        if (full !== 1'b1) begin errors++; $display("FAIL fill_full got %b want 1", full); end
        if (count !== 5'd16) begin errors++; $display("FAIL fill_count got %0d want 16", count); end
        drain_and_check("fill_drain");
        for (int i = 0; i < 3; i++) send_byte(8'h80 + 8'(i));
        checks += 1;
        if (count !== 5'd3) begin errors++; $display("FAIL wrap_count got %0d want 3", count); end
        drain_and_check("wrap_drain");
    endtask

    task automatic test_overflow();
        for (int i = 0; i < DEPTH; i++) send_byte(8'h40 + 8'(i));
        cyc(1'b1, 1'b1, 8'hEE, 1'b0, 1'b0);
        checks += 3;
        if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_set got %b want 1", overflow); end
        if (count !== 5'd16) begin errors++; $display("FAIL ovf_count got %0d want 16", count); end
        if (rx_clear_ready !== 1'b1) begin errors++; $display("FAIL ovf_ack got %b want 1", rx_clear_ready); end
        cyc(1'b1, 1'b0, 8'hEE, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 8'hEE, 1'b0, 1'b0);
        checks += 1;
        if (rx_clear_ready !== 1'b0) begin errors++; $display("FAIL ovf_ack_end got %b want 0", rx_clear_ready); end
        cyc(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
        checks += 1;
        if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_clear got %b want 0", overflow); end
        // Drop and clear in the same cycle: set must win
        cyc(1'b1, 1'b1, 8'hEF, 1'b0, 1'b1);
        checks += 1;
        if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_set_wins got %b want 1", overflow); end
        cyc(1'b1, 1'b0, 8'hEF, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 8'hEF, 1'b0, 1'b1);
        checks += 1;
        if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_clear2 got %b want 0", overflow); end
        // Full with a same-cycle pop: byte accepted
        cyc(1'b1, 1'b1, 8'hBB, 1'b1, 1'b0);
        checks += 4;
        if (count !== 5'd16) begin errors++; $display("FAIL fullpop_count got %0d want 16", count); end
        if (overflow !== 1'b0) begin errors++; $display("FAIL fullpop_ovf got %b want 0", overflow); end
        if (valid !== 1'b1) begin errors++; $display("FAIL fullpop_valid got %b want 1", valid); end
        if (data !== exp_data()) begin errors++; $display("FAIL fullpop_data got %h want %h", data, exp_data()); end
        cyc(1'b1, 1'b0, 8'hBB, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 8'hBB, 1'b0, 1'b0);
        drain_and_check("fullpop_drain");
    endtask

    task automatic test_read_empty();
        cyc(1'b1, 1'b1, 8'h3C, 1'b1, 1'b0);
        checks += 2;
        if (valid !== exp_valid()) begin errors++; $display("FAIL rdempty_valid got %b want %b", valid, exp_valid()); end
        if (count !== 5'd1) begin errors++; $display("FAIL rdempty_count got %0d want 1", count); end
        cyc(1'b1, 1'b0, 8'h3C, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 8'h3C, 1'b0, 1'b0);
        checks += 1;
        if (valid !== exp_valid()) begin errors++; $display("FAIL rdempty_valid2 got %b want %b", valid, exp_valid()); end
        drain_and_check("rdempty_pop");
    endtask

    task automatic test_reset_mid();
        apply_reset();
        for (int i = 0; i < 4; i++) send_byte(8'h10 + 8'(i));
        cyc(1'b1, 1'b1, 8'h14, 1'b0, 1'b0);
        checks += 1;
        if (count !== 5'd5) begin errors++; $display("FAIL mid_count_pre got %0d want 5", count); end
        #2;
        rst = 1'b1;
        #1;
        checks += 5;
        if (rx_clear_ready !== 1'b0) begin errors++; $display("FAIL mid_clear got %b want 0", rx_clear_ready); end
        if (count !== '0) begin errors++; $display("FAIL mid_count got %0d want 0", count); end
        if (empty !== 1'b1) begin errors++; $display("FAIL mid_empty got %b want 1", empty); end
        if (valid !== 1'b0) begin errors++; $display("FAIL mid_valid got %b want 0", valid); end
        if (overflow !== 1'b0) begin errors++; $display("FAIL mid_ovf got %b want 0", overflow); end
        rx_ready = 1'b0;
        mdl_q.delete();
        mdl_ovf   = 1'b0;
        mdl_valid = 1'b0;
        mdl_data  = 8'h00;
        @(posedge clk);
        #1;
        rst = 1'b0;
        send_byte(8'h77);
        checks += 1;
        if (count !== 5'd1) begin errors++; $display("FAIL mid_recover_count got %0d want 1", count); end
        drain_and_check("mid_recover");
    endtask

    task automatic test_random();
        int gap;
        int phase;
        int rd_pct;
        logic [7:0] b;
        logic exp_clr;
        for (int n = 0; n < 90; n++) begin
            rd_pct = (n < 45) ? 15 : 60;
            gap    = $urandom_range(0, 2);
            b      = 8'($urandom_range(0, 255));
            for (int k = 0; k < gap + 3; k++) begin
                phase = k - gap;
                cyc((phase == 0) || (phase == 1), phase == 0, b,
                    $urandom_range(0, 99) < rd_pct, $urandom_range(0, 15) == 0);
                exp_clr = (phase == 0) || (phase == 1);
                checks += 6;
                if (count !== exp_count()) begin errors++; $display("FAIL rnd_count got %0d want %0d", count, exp_count()); end
                if (empty !== (mdl_q.size() == 0)) begin errors++; $display("FAIL rnd_empty got %b", empty); end
                if (full !== (mdl_q.size() == DEPTH)) begin errors++; $display("FAIL rnd_full got %b", full); end
                if (overflow !== mdl_ovf) begin errors++; $display("FAIL rnd_ovf got %b want %b", overflow, mdl_ovf); end
                if (rx_clear_ready !== exp_clr) begin errors++; $display("FAIL rnd_clear got %b want %b", rx_clear_ready, exp_clr); end
                if (valid !== exp_valid()) begin errors++; $display("FAIL rnd_valid got %b want %b", valid, exp_valid()); end
                if (data_checked()) begin
                    checks += 1;
                    if (data !== exp_data()) begin errors++; $display("FAIL rnd_data got %h want %h", data, exp_data()); end
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_byte();
        test_fill_wrap();
        test_overflow();
        test_read_empty();
        test_random();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
